inst_encoder: RTL

Pipelined AArch64-subset instruction encoder: accepts an `opcode_t` plus operand fields and emits the 32-bit instruction word that the fetch-side opcode decoder maps back to the same `opcode_t`. It is the inverse of that decoder. It sits in the program-loader / test-stimulus path, feeding instruction memory or the fetch bench. It uses a 2-stage valid/ready pipeline with backpressure and flags unsupported ops and out-of-range immediates.

---
 rtl/op_pkg.sv | 76 +++++++
 rtl/inst_encoder_if.sv | 27 ++
 rtl/inst_pack.sv | 61 ++++++
 rtl/inst_encoder.sv | 59 +++++
 4 files changed

// File: rtl/op_pkg.sv
// op_pkg: opcode type, encoding prefixes and immediate-field classes shared by the encoder and decoder
package op_pkg;

    typedef enum logic [5:0] {
        OPCODE_ERROR, OPCODE_LDUR, OPCODE_STUR, OPCODE_F_LDUR, OPCODE_F_STUR,
        OPCODE_MOVZ, OPCODE_MOVK, OPCODE_ADD, OPCODE_SUB, OPCODE_ADDS, OPCODE_SUBS,
        OPCODE_CMN, OPCODE_CMP, OPCODE_ORR, OPCODE_EOR, OPCODE_ANDS, OPCODE_TST,
        OPCODE_MVN, OPCODE_LSL, OPCODE_LSR, OPCODE_ASR, OPCODE_B, OPCODE_BL,
        OPCODE_B_COND, OPCODE_ADRP, OPCODE_RET, OPCODE_NOP, OPCODE_HLT,
        OPCODE_FMOV, OPCODE_FNEG, OPCODE_FCMP, OPCODE_FCMPR, OPCODE_FADD,
        OPCODE_FSUB, OPCODE_FMUL
    } opcode_t;

    typedef enum logic [2:0] {
        IMM9_S, IMM12_U, IMM16_U, IMM19_S, IMM21_S, IMM26_S, SHIFT6_U, NONE
    } field_class_t;

    typedef struct packed {
        opcode_t     op;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [31:0] imm;
        logic [1:0]  hw;
        logic [3:0]  cond;
    } enc_req_t;

    localparam logic [10:0] P_LDUR   = 11'b11111000010;
    localparam logic [10:0] P_STUR   = 11'b11111000000;
    localparam logic [10:0] P_F_LDUR = 11'b11111100010;
    localparam logic [10:0] P_F_STUR = 11'b11111100000;
    localparam logic [10:0] P_ADDS   = 11'b10101011000;
    localparam logic [10:0] P_SUBS   = 11'b11101011000;
    localparam logic [10:0] P_ORR    = 11'b10101010000;
    localparam logic [10:0] P_EOR    = 11'b11001010000;
    localparam logic [10:0] P_ANDS   = 11'b11101010000;
    localparam logic [10:0] P_MVN    = 11'b10101010001;
    localparam logic [10:0] P_FP     = 11'b00011110011;
    localparam logic [9:0]  P_ADDI   = 10'b1001000100;
    localparam logic [9:0]  P_SUBI   = 10'b1101000100;
    localparam logic [9:0]  P_UBFM   = 10'b1101001101;
    localparam logic [9:0]  P_SBFM   = 10'b1001001101;
    localparam logic [8:0]  P_MOVZ   = 9'b110100101;
    localparam logic [8:0]  P_MOVK   = 9'b111100101;
    localparam logic [7:0]  P_BCOND  = 8'b01010100;
    localparam logic [5:0]  P_B      = 6'b000101;
    localparam logic [5:0]  P_BL     = 6'b100101;

    function automatic field_class_t field_class(opcode_t op);
        case (op)
            OPCODE_LDUR, OPCODE_STUR, OPCODE_F_LDUR, OPCODE_F_STUR: return IMM9_S;
            OPCODE_ADD, OPCODE_SUB:                                 return IMM12_U;
            OPCODE_MOVZ, OPCODE_MOVK, OPCODE_HLT:                   return IMM16_U;
            OPCODE_B_COND:                                          return IMM19_S;
            OPCODE_ADRP:                                            return IMM21_S;
            OPCODE_B, OPCODE_BL:                                    return IMM26_S;
            OPCODE_LSL, OPCODE_LSR, OPCODE_ASR:                     return SHIFT6_U;
            default:                                                return NONE;
        endcase
    endfunction

    // Signed fields must be a sign-extension; unsigned fields must have no bits above the field
    function automatic logic imm_ok(field_class_t c, logic [31:0] imm);
        case (c)
            IMM9_S:   return &imm[31:8]  || ~|imm[31:8];
            IMM12_U:  return ~|imm[31:12];
            IMM16_U:  return ~|imm[31:16];
            IMM19_S:  return &imm[31:18] || ~|imm[31:18];
            IMM21_S:  return &imm[31:20] || ~|imm[31:20];
            IMM26_S:  return &imm[31:25] || ~|imm[31:25];
            SHIFT6_U: return ~|imm[31:6];
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// inst_encoder_if: request/response handshake bundle of the instruction encoder
interface inst_encoder_if;
    import op_pkg::*;
    logic        in_valid;
    logic        in_ready;
    opcode_t     in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rn;
    logic [4:0]  in_rm;
    logic [31:0] in_imm;
    logic [1:0]  in_hw;
    logic [3:0]  in_cond;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [15:0] err_count;

    modport master (
        output in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_hw, in_cond, out_ready,
        input  in_ready, out_valid, out_inst, out_err, err_count
    );
    modport slave (
        input  in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_hw, in_cond, out_ready,
        output in_ready, out_valid, out_inst, out_err, err_count
    );
endinterface

// File: rtl/inst_pack.sv
// inst_pack: combinational (op, fields) -> (32-bit AArch64 word, error) packer
module inst_pack
    import op_pkg::*;
(
    input  enc_req_t    req_i,
    output logic [31:0] word_o,
    output logic        err_o
);
    logic [31:0] i;
    logic [4:0]  rd, rn, rm;
    logic [5:0]  s;

    assign i  = req_i.imm;
    assign rd = req_i.rd;
    assign rn = req_i.rn;
    assign rm = req_i.rm;
    assign s  = req_i.imm[5:0];

    always_comb begin
        word_o = '0;
        err_o  = !imm_ok(field_class(req_i.op), i);
        case (req_i.op)
            OPCODE_LDUR:   word_o = {P_LDUR, i[8:0], 2'b00, rn, rd};
            OPCODE_STUR:   word_o = {P_STUR, i[8:0], 2'b00, rn, rd};
            OPCODE_F_LDUR: word_o = {P_F_LDUR, i[8:0], 2'b00, rn, rd};
            OPCODE_F_STUR: word_o = {P_F_STUR, i[8:0], 2'b00, rn, rd};
            OPCODE_MOVZ:   word_o = {P_MOVZ, req_i.hw, i[15:0], rd};
            OPCODE_MOVK:   word_o = {P_MOVK, req_i.hw, i[15:0], rd};
            OPCODE_ADD:    word_o = {P_ADDI, i[11:0], rn, rd};
            OPCODE_SUB:    word_o = {P_SUBI, i[11:0], rn, rd};
            OPCODE_ADDS:   word_o = {P_ADDS, rm, 6'b0, rn, rd};
            OPCODE_SUBS:   word_o = {P_SUBS, rm, 6'b0, rn, rd};
            OPCODE_ORR:    word_o = {P_ORR, rm, 6'b0, rn, rd};
            OPCODE_EOR:    word_o = {P_EOR, rm, 6'b0, rn, rd};
            OPCODE_ANDS:   word_o = {P_ANDS, rm, 6'b0, rn, rd};
            OPCODE_CMN:    word_o = {P_ADDS, rm, 6'b0, rn, 5'd31};
            OPCODE_CMP:    word_o = {P_SUBS, rm, 6'b0, rn, 5'd31};
            OPCODE_TST:    word_o = {P_ANDS, rm, 6'b0, rn, 5'd31};
            OPCODE_MVN:    word_o = {P_MVN, rm, 6'b0, 5'd31, rd};
            // LSL is UBFM with immr=-s, imms=63-s; LSL #0 lands on the LSR #0 word
            OPCODE_LSL:    word_o = {P_UBFM, 6'd0 - s, ~s, rn, rd};
            OPCODE_LSR:    word_o = {P_UBFM, s, 6'd63, rn, rd};
            OPCODE_ASR:    word_o = {P_SBFM, s, 6'd63, rn, rd};
            OPCODE_B:      word_o = {P_B, i[25:0]};
            OPCODE_BL:     word_o = {P_BL, i[25:0]};
            OPCODE_B_COND: word_o = {P_BCOND, i[18:0], 1'b0, req_i.cond};
            OPCODE_ADRP:   word_o = {1'b1, i[1:0], 5'b10000, i[20:2], rd};
            OPCODE_RET:    word_o = 32'hD65F_0000 | {22'd0, rn, 5'd0};
            OPCODE_NOP:    word_o = 32'hD503_201F;
            OPCODE_HLT:    word_o = 32'hD440_0000 | {11'd0, i[15:0], 5'd0};
            OPCODE_FMOV:   word_o = {P_FP, 5'd0, 6'b010000, rn, rd};
            OPCODE_FNEG:   word_o = {P_FP, 5'd1, 6'b010000, rn, rd};
            OPCODE_FCMP:   word_o = {P_FP, 5'd0, 6'b001000, rn, 5'b01000};
            OPCODE_FCMPR:  word_o = {P_FP, rm, 6'b001000, rn, 5'b00000};
            OPCODE_FADD:   word_o = {P_FP, rm, 6'b001010, rn, rd};
            OPCODE_FSUB:   word_o = {P_FP, rm, 6'b001110, rn, rd};
            OPCODE_FMUL:   word_o = {P_FP, rm, 6'b000010, rn, rd};
            default:       err_o  = 1'b1;
        endcase
    end
endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: two-stage valid/ready pipeline around inst_pack with a saturating error counter
module inst_encoder
    import op_pkg::*;
(
    input  logic          clk_in,
    input  logic          rst_N_in,
    inst_encoder_if.slave bus
);
    enc_req_t    req, s1_q, s1_d;
    logic        s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [31:0] inst_q, inst_d, word;
    logic        err_q, err_d, err;
    logic [15:0] cnt_q, cnt_d;
    logic        s1_load, s2_load;

    assign req = '{op: bus.in_op, rd: bus.in_rd, rn: bus.in_rn, rm: bus.in_rm,
                   imm: bus.in_imm, hw: bus.in_hw, cond: bus.in_cond};
    assign s2_load = !s2_valid_q || bus.out_ready;
    assign s1_load = !s1_valid_q || s2_load;

    inst_pack u_pack (
        .req_i  (s1_q),
        .word_o (word),
        .err_o  (err)
    );

    always_comb begin
        s1_valid_d = s1_load ? bus.in_valid : s1_valid_q;
        s1_d       = (s1_load && bus.in_valid) ? req : s1_q;
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        inst_d     = (s2_load && s1_valid_q) ? word : inst_q;
        err_d      = (s2_load && s1_valid_q) ? err : err_q;
        cnt_d      = (s2_valid_q && bus.out_ready && err_q && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            inst_q     <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            inst_q     <= inst_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.in_ready  = s1_load;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_inst  = inst_q;
    assign bus.out_err   = err_q;
    assign bus.err_count = cnt_q;
endmodule
